// File: rtl/rfile_mp.sv
// rfile_mp: parameterised register file with two write ports and two
// combinational read ports. Port B wins write collisions. Optional
// write-to-read bypass and an optional hardwired zero register ($zero).
// A synchronous clear zeroes the whole file in one edge.
module rfile_mp #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              reg_write_a,
  input  logic [ADDR_W-1:0] w_addr_a,
  input  logic [WIDTH-1:0]  w_data_a,
  input  logic              reg_write_b,
  input  logic [ADDR_W-1:0] w_addr_b,
  input  logic [WIDTH-1:0]  w_data_b,
  input  logic [ADDR_W-1:0] r_addr1,
  input  logic [ADDR_W-1:0] r_addr2,
  output logic [WIDTH-1:0]  r_data1,
  output logic [WIDTH-1:0]  r_data2
);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];

  logic wr_ok_a;
  logic wr_ok_b;

  // A write is effective only if enabled and not aimed at a hardwired $zero.
  always_comb begin
    wr_ok_a = reg_write_a;
    wr_ok_b = reg_write_b;
    if (ZERO_REG != 0) begin
      if (w_addr_a == '0) wr_ok_a = 1'b0;
      if (w_addr_b == '0) wr_ok_b = 1'b0;
    end
  end

  // Next-state of the array: clear wipes everything and drops both writes;
  // otherwise A is applied first so a colliding B write overrides it.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_d[i] = '0;
      end
    end else begin
      if (wr_ok_a) regs_d[w_addr_a] = w_data_a;
      if (wr_ok_b) regs_d[w_addr_b] = w_data_b;
    end
  end

  // Storage flops; asynchronous active-low reset clears the whole file.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Read mux priority: forced zero, bypass B, bypass A, stored value.
  // Bypass is suppressed during clear so reads show pre-clear contents.
  function automatic logic [WIDTH-1:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [WIDTH-1:0] val;
    val = regs_q[addr];
    if (!reset) begin
      val = '0;
    end else if ((ZERO_REG != 0) && (addr == '0)) begin
      val = '0;
    end else if ((BYPASS != 0) && !clear && wr_ok_b && (w_addr_b == addr)) begin
      val = w_data_b;
    end else if ((BYPASS != 0) && !clear && wr_ok_a && (w_addr_a == addr)) begin
      val = w_data_a;
    end
    return val;
  endfunction

  // Two independent combinational read ports.
  always_comb begin
    r_data1 = read_port(r_addr1);
    r_data2 = read_port(r_addr2);
  end

endmodule

// File: tb/tb_rfile_mp.sv
// Directed bench for rfile_mp: default configuration, ZERO_REG=0,
// BYPASS=0 and a narrow/shallow WIDTH=16, DEPTH=8 instance.
module tb_rfile_mp;

  logic        clock;
  logic        reset;
  logic        clear;
  logic        we_a, we_b;
  logic [4:0]  wa_a, wa_b, ra1, ra2;
  logic [31:0] wd_a, wd_b;
  logic [31:0] d_rd1, d_rd2, nz_rd1, nz_rd2, nb_rd1, nb_rd2;

  logic        s_we_a, s_we_b;
  logic [2:0]  s_wa_a, s_wa_b, s_ra1, s_ra2;
  logic [15:0] s_wd_a, s_wd_b;
  logic [15:0] s_rd1, s_rd2;

  int vectors;
  int miscompares;

  rfile_mp u_dut (
    .clock(clock), .reset(reset), .clear(clear),
    .reg_write_a(we_a), .w_addr_a(wa_a), .w_data_a(wd_a),
    .reg_write_b(we_b), .w_addr_b(wa_b), .w_data_b(wd_b),
    .r_addr1(ra1), .r_addr2(ra2), .r_data1(d_rd1), .r_data2(d_rd2)
  );

  rfile_mp #(.ZERO_REG(0)) u_nz (
    .clock(clock), .reset(reset), .clear(clear),
    .reg_write_a(we_a), .w_addr_a(wa_a), .w_data_a(wd_a),
    .reg_write_b(we_b), .w_addr_b(wa_b), .w_data_b(wd_b),
    .r_addr1(ra1), .r_addr2(ra2), .r_data1(nz_rd1), .r_data2(nz_rd2)
  );

  rfile_mp #(.BYPASS(0)) u_nb (
    .clock(clock), .reset(reset), .clear(clear),
    .reg_write_a(we_a), .w_addr_a(wa_a), .w_data_a(wd_a),
    .reg_write_b(we_b), .w_addr_b(wa_b), .w_data_b(wd_b),
    .r_addr1(ra1), .r_addr2(ra2), .r_data1(nb_rd1), .r_data2(nb_rd2)
  );

  rfile_mp #(.WIDTH(16), .DEPTH(8)) u_small (
    .clock(clock), .reset(reset), .clear(clear),
    .reg_write_a(s_we_a), .w_addr_a(s_wa_a), .w_data_a(s_wd_a),
    .reg_write_b(s_we_b), .w_addr_b(s_wa_b), .w_data_b(s_wd_b),
    .r_addr1(s_ra1), .r_addr2(s_ra2), .r_data1(s_rd1), .r_data2(s_rd2)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic ea, input logic [4:0] aa, input logic [31:0] da,
                       input logic eb, input logic [4:0] ab, input logic [31:0] db);
    we_a = ea; wa_a = aa; wd_a = da;
    we_b = eb; wa_b = ab; wd_b = db;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    s_we_a = 1'b0; s_we_b = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b0;
    clear = 1'b0;
    idle();
    ra1 = 5'd5; ra2 = 5'd9;
    s_wa_a = '0; s_wa_b = '0; s_wd_a = '0; s_wd_b = '0; s_ra1 = '0; s_ra2 = '0;

    #2;
    chk("reset_rd1", d_rd1, 32'h0);
    chk("reset_rd2", d_rd2, 32'h0);
    chk("reset_small", {16'h0, s_rd1}, 32'h0);
    #10 reset = 1'b1;   // released between edges
    step();

    // Reset: load r1..31, then assert reset mid-cycle
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, 5'(i), 32'hA5A5_0000 + 32'(i), 1'b0, 5'd0, 32'h0);
      step();
    end
    idle();
    ra1 = 5'd31; ra2 = 5'd1;
    #1;
    chk("load_r31", d_rd1, 32'hA5A5_001F);
    chk("load_r1", d_rd2, 32'hA5A5_0001);
    #2 reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(31 - i);
      #1;
      chk("in_reset_rd1", d_rd1, 32'h0);
      chk("in_reset_rd2", d_rd2, 32'h0);
    end
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i);
      #1;
      chk("post_reset", d_rd1, 32'h0);
    end
    step();

    // Write/read on both ports
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd9, 32'h12345678);
    step();
    idle();
    ra1 = 5'd5; ra2 = 5'd9;
    #1;
    chk("wr_r5", d_rd1, 32'hDEADBEEF);
    chk("wr_r9", d_rd2, 32'h12345678);
    chk("wr_r5_nb", nb_rd1, 32'hDEADBEEF);

    // Collision on r7, plus a lone A write to r10 for A-only bypass
    drive(1'b1, 5'd7, 32'h1111_1111, 1'b1, 5'd7, 32'h2222_2222);
    ra1 = 5'd7;
    #1;
    chk("coll_bypass", d_rd1, 32'h2222_2222);
    chk("coll_nb_old", nb_rd1, 32'h0);
    step();
    drive(1'b1, 5'd10, 32'h0000_CAFE, 1'b0, 5'd0, 32'h0);
    ra2 = 5'd10;
    #1;
    chk("coll_stored", d_rd1, 32'h2222_2222);
    chk("coll_stored_nb", nb_rd1, 32'h2222_2222);
    chk("bypass_a", d_rd2, 32'h0000_CAFE);
    step();
    idle();

    // Zero register
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    ra1 = 5'd0;
    #1;
    chk("zero_during", d_rd1, 32'h0);
    step();
    idle();
    #1;
    chk("zero_after", d_rd1, 32'h0);
    chk("nz_after", nz_rd1, 32'hFFFF_FFFF);

    // Bypass off
    drive(1'b1, 5'd3, 32'h0000_0001, 1'b0, 5'd0, 32'h0);
    step();
    drive(1'b1, 5'd3, 32'h0000_00AB, 1'b0, 5'd0, 32'h0);
    ra1 = 5'd3;
    #1;
    chk("nb_during", nb_rd1, 32'h0000_0001);
    chk("byp_during", d_rd1, 32'h0000_00AB);
    step();
    idle();
    #1;
    chk("nb_after", nb_rd1, 32'h0000_00AB);

    // Clear with a colliding write that must be dropped
    drive(1'b1, 5'd4, 32'h55, 1'b0, 5'd0, 32'h0);
    step();
    clear = 1'b1;
    drive(1'b1, 5'd4, 32'h77, 1'b0, 5'd0, 32'h0);
    ra1 = 5'd4; ra2 = 5'd5;
    #1;
    chk("clear_during", d_rd1, 32'h55);
    chk("clear_during_r5", d_rd2, 32'hDEADBEEF);
    step();
    clear = 1'b0;
    idle();
    #1;
    chk("clear_r4", d_rd1, 32'h0);
    chk("clear_r5", d_rd2, 32'h0);
    chk("clear_nz_r0", nz_rd1, 32'h0);
    ra1 = 5'd0;
    #1;
    chk("clear_nz_r0b", nz_rd1, 32'h0);

    // Narrow instance: write/read and collision
    s_we_a = 1'b1; s_wa_a = 3'd5; s_wd_a = 16'hBEEF;
    s_we_b = 1'b1; s_wa_b = 3'd6; s_wd_b = 16'h5678;
    step();
    idle();
    s_ra1 = 3'd5; s_ra2 = 3'd6;
    #1;
    chk("small_r5", {16'h0, s_rd1}, 32'h0000_BEEF);
    chk("small_r6", {16'h0, s_rd2}, 32'h0000_5678);
    s_we_a = 1'b1; s_wa_a = 3'd7; s_wd_a = 16'h1111;
    s_we_b = 1'b1; s_wa_b = 3'd7; s_wd_b = 16'h2222;
    s_ra1 = 3'd7;
    #1;
    chk("small_coll_byp", {16'h0, s_rd1}, 32'h0000_2222);
    step();
    idle();
    #1;
    chk("small_coll", {16'h0, s_rd1}, 32'h0000_2222);
    chk("small_r6_kept", {16'h0, s_rd2}, 32'h0000_5678);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rfile_mp.md
# rfile_mp

Parametrised multi-port register file, successor to the single-write-port MIPS32 `rfile`. It serves the decode stage of the pipelined MIPS32 core. Width and depth are configurable, and it provides two write ports with deterministic collision priority. Optional write-to-read bypass removes the WB→ID hazard, and an optional hardwired zero register implements MIPS `$zero`. A synchronous clear flushes the whole file in one cycle.

## Interface
- `WIDTH`, default 32: data width in bits.
- `DEPTH`, default 32: number of registers; power of two, ≥2.
- `ADDR_W`, default `$clog2(DEPTH)`: address width; derived, do not override.
- `ZERO_REG`, default 1: 1 means register 0 reads as 0 and ignores writes.
- `BYPASS`, default 1: 1 means same-cycle write data is forwarded to matching read ports.

Ports:
- `clock` in, 1: rising-edge clock.
- `reset` in, 1: asynchronous, active-low reset.
- `clear` in, 1: synchronous flush of all registers to 0.
- `reg_write_a` in, 1: write enable, port A.
- `w_addr_a` in, `ADDR_W`: write address, port A.
- `w_data_a` in, `WIDTH`: write data, port A.
- `reg_write_b` in, 1: write enable, port B. Port B has priority over port A.
- `w_addr_b` in, `ADDR_W`: write address, port B.
- `w_data_b` in, `WIDTH`: write data, port B.
- `r_addr1` in, `ADDR_W`: read address, port 1.
- `r_addr2` in, `ADDR_W`: read address, port 2.
- `r_data1` out, `WIDTH`: read data, port 1 (combinational).
- `r_data2` out, `WIDTH`: read data, port 2 (combinational).

## Operation
- Storage is `DEPTH` × `WIDTH` flops, updated only on the rising edge of `clock` or on an asynchronous reset.
- **Reset:** `reset`=0 clears every register to 0 immediately, independent of `clock`. While `reset`=0, `r_data1` and `r_data2` are forced to 0 and bypass is suppressed.
- **Clear:** `clear`=1 at an edge zeroes all registers. Both writes in that cycle are dropped. While `clear`=1, bypass is suppressed and reads return the stored (pre-clear) contents.
- **Write:** at an edge with `reset`=1 and `clear`=0:
  - If `reg_write_a` is set, `w_data_a` is stored to `w_addr_a`.
  - If `reg_write_b` is set, `w_data_b` is stored to `w_addr_b`.
  - If both are enabled with equal addresses, port B's data is stored and port A's is discarded.
- **Zero register** (`ZERO_REG`=1): writes to address 0 are ignored on both ports. Reads of address 0 return 0 regardless of bypass. With `ZERO_REG`=0, register 0 is ordinary.
- **Read:** purely combinational from `r_addr*`.
  - Read-port priority: forced 0 (reset or zero register), then bypass B, then bypass A, then stored value.
  - Bypass (`BYPASS`=1, `clear`=0): if `reg_write_b` is set and `w_addr_b`==`r_addrN` (and the address is writable), `r_dataN`=`w_data_b`. Otherwise, the same test is applied to port A. Otherwise the stored value is returned.
  - With `BYPASS`=0, reads return stored values only. A same-cycle write becomes visible after the edge.
- Both read ports are independent; the same address may be read on both ports.

## Timing
- Write latency: 1 edge. Without bypass, data is readable in the cycle after the write edge. With bypass, it is readable combinationally in the write cycle.
- Read latency: 0 cycles (combinational path address→data and write-data→read-data).
- Reset assertion takes effect asynchronously. On deassertion, the first write can occur at the next rising edge.
- If `reset` is asserted mid-cycle while writes are pending, the writes are lost. All registers read 0 until new writes land.
- `clear` and `reset` together: reset dominates. The result (all registers 0) is identical.
- Reset value of every register and both outputs: 0.

## Test plan
- **Reset:** load registers 1..31 with `32'hA5A5_0000+i`, then assert `reset`=0 mid-cycle → `r_data1`/`r_data2` read 0 immediately for every address; after release, every register still reads 0.
- **Write/read:** write `32'hDEADBEEF` to r5 via A and `32'h12345678` to r9 via B in one cycle. In the next cycle, reading r5/r9 → `32'hDEADBEEF`/`32'h12345678`.
- **Collision:** A and B both write r7, with A=`32'h1111_1111` and B=`32'h2222_2222` → r7 reads `32'h2222_2222`. During the write cycle with `BYPASS`=1, `r_addr1`=7 also returns `32'h2222_2222`.
- **Zero register:** B writes `32'hFFFF_FFFF` to r0 with `ZERO_REG`=1 → r0 reads 0 both during the write cycle and after. With `ZERO_REG`=0, r0 reads `32'hFFFF_FFFF` after the edge.
- **Bypass off:** with `BYPASS`=0, A writes `32'h0000_00AB` to r3 while reading r3 (old value `32'h0000_0001`) → reads `32'h0000_0001` during the write cycle and `32'h0000_00AB` after the edge.
- **Clear:** with r4=`32'h55`, pulse `clear` while A writes `32'h77` to r4 → r4 reads `32'h55` during the clear cycle (no bypass) and 0 after. The dropped write is never visible.
- **Parameters:** repeat the write/read and collision scenarios with `WIDTH`=16, `DEPTH`=8.
